// File: rtl/gpio_in_if.sv
// Single-cycle CPU IO bus as seen by the gpio_in peripheral.
// The master drives address/control/write data; the slave returns combinational read data.
interface gpio_in_if;
    logic [31:0] io_addr;
    logic        io_op;
    logic [3:0]  io_mask;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;

    modport master (output io_addr, io_op, io_mask, io_wdata, input io_rdata);
    modport slave  (input io_addr, io_op, io_mask, io_wdata, output io_rdata);
endinterface

// File: rtl/gpio_in.sv
// General-purpose input block: synchronize, debounce and edge-detect input pins,
// latching enabled edges into a sticky W1C status register that drives a level interrupt.
module gpio_in #(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 0
) (
    input  logic             clk,
    input  logic             rst,
    gpio_in_if.slave         bus,
    input  logic [WIDTH-1:0] io_gpio,
    output logic             io_irq
);
    localparam int CW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE);

    logic [WIDTH-1:0] s1_p0;
    logic [WIDTH-1:0] s2_p1;
    logic [WIDTH-1:0] filt_p2;
    logic [CW-1:0]    cnt_p2 [WIDTH];

    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] status;

    logic [WIDTH-1:0] upd;
    logic [WIDTH-1:0] set_evt;
    logic [WIDTH-1:0] clr_evt;
    logic [31:0]      lane_mask;
    logic [31:0]      wdata_m;
    logic             wr_rise;
    logic             wr_fall;
    logic             wr_stat;

    always_comb begin
        upd = '0;
        for (int i = 0; i < WIDTH; i++) begin
            upd[i] = (s2_p1[i] != filt_p2[i]) && (cnt_p2[i] == DEB_MAX);
        end
        // An edge is exactly the bit where filt is about to take the new s2 value
        set_evt = upd & ((s2_p1 & ~filt_p2 & rise_en) | (~s2_p1 & filt_p2 & fall_en));

        lane_mask = {{8{bus.io_mask[3]}}, {8{bus.io_mask[2]}},
                     {8{bus.io_mask[1]}}, {8{bus.io_mask[0]}}};
        wdata_m   = bus.io_wdata & lane_mask;
        wr_rise   = bus.io_op && (bus.io_addr[3:2] == 2'd1);
        wr_fall   = bus.io_op && (bus.io_addr[3:2] == 2'd2);
        wr_stat   = bus.io_op && (bus.io_addr[3:2] == 2'd3);
        clr_evt   = wr_stat ? wdata_m[WIDTH-1:0] : '0;
    end

    // Synchronizer (p0, p1) and debounce filter (p2)
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_p0   <= '0;
            s2_p1   <= '0;
            filt_p2 <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_p2[i] <= '0;
        end else begin
            s1_p0 <= io_gpio;
            s2_p1 <= s1_p0;
            for (int i = 0; i < WIDTH; i++) begin
                if (s2_p1[i] == filt_p2[i]) begin
                    cnt_p2[i] <= '0;
                end else if (cnt_p2[i] == DEB_MAX) begin
                    filt_p2[i] <= s2_p1[i];
                    cnt_p2[i]  <= '0;
                end else begin
                    cnt_p2[i] <= cnt_p2[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_en <= '0;
            fall_en <= '0;
            status  <= '0;
        end else begin
            if (wr_rise) rise_en <= (rise_en & ~lane_mask[WIDTH-1:0]) | wdata_m[WIDTH-1:0];
            if (wr_fall) fall_en <= (fall_en & ~lane_mask[WIDTH-1:0]) | wdata_m[WIDTH-1:0];
            // A new edge wins over a simultaneous clear of the same bit
            status <= (status & ~clr_evt) | set_evt;
        end
    end

    always_comb begin
        bus.io_rdata = '0;
        case (bus.io_addr[3:2])
            2'd0:    bus.io_rdata = 32'(filt_p2);
            2'd1:    bus.io_rdata = 32'(rise_en);
            2'd2:    bus.io_rdata = 32'(fall_en);
            default: bus.io_rdata = 32'(status);
        endcase
    end

    assign io_irq = |status;

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.io_addr, wdata_m, lane_mask};
endmodule

// File: tb/tb_gpio_in.sv
// Directed bench for gpio_in: one instance without and one with debounce, scoreboard-checked reads.
module tb_gpio_in;
    localparam logic [1:0] A_IN = 2'd0, A_RISE = 2'd1, A_FALL = 2'd2, A_STAT = 2'd3;

    logic       clk = 1'b0;
    logic       rst0 = 1'b1;
    logic       rst4 = 1'b1;
    logic [7:0] g0 = 8'hFF;
    logic [7:0] g4 = 8'h00;
    logic       irq0, irq4;

    gpio_in_if b0 ();
    gpio_in_if b4 ();

    gpio_in #(.WIDTH(8), .DEBOUNCE(0)) u0 (.clk(clk), .rst(rst0), .bus(b0.slave), .io_gpio(g0), .io_irq(irq0));
    gpio_in #(.WIDTH(8), .DEBOUNCE(4)) u4 (.clk(clk), .rst(rst4), .bus(b4.slave), .io_gpio(g4), .io_irq(irq4));

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          sel;
        logic [31:0] rdata;
        logic        irq;
    } exp_t;

    exp_t q[$];
    bit   chk_req = 1'b0;
    bit   done = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Monitor: pops one expectation per presented read and compares both outputs
    always @(negedge clk) begin
        if (chk_req) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: read presented with no expectation queued");
            end else begin
                exp_t e;
                logic [31:0] ard;
                logic        airq;
                e    = q.pop_front();
                ard  = e.sel ? b4.io_rdata : b0.io_rdata;
                airq = e.sel ? irq4 : irq0;
                checks++;
                if (ard !== e.rdata) begin
                    errors++;
                    $display("FAIL %s rdata: got 0x%08h expected 0x%08h", e.name, ard, e.rdata);
                end
                checks++;
                if (airq !== e.irq) begin
                    errors++;
                    $display("FAIL %s irq: got %0b expected %0b", e.name, airq, e.irq);
                end
            end
        end
    end

    task automatic drive(input bit sel, input logic [1:0] a, input logic op,
                         input logic [3:0] m, input logic [31:0] d);
        if (sel) begin
            b4.io_addr = {28'd0, a, 2'b00}; b4.io_op = op; b4.io_mask = m; b4.io_wdata = d;
        end else begin
            b0.io_addr = {28'd0, a, 2'b00}; b0.io_op = op; b0.io_mask = m; b0.io_wdata = d;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    task automatic wr(input bit sel, input logic [1:0] a, input logic [3:0] m, input logic [31:0] d);
        drive(sel, a, 1'b1, m, d);
        tick();
        drive(sel, a, 1'b0, 4'h0, 32'h0);
    endtask

    // Queue the expectation for the current cycle's read, then advance one edge
    task automatic chk(input bit sel, input logic [1:0] a, input logic [31:0] exp_rd,
                       input logic exp_irq, input string name);
        exp_t e;
        drive(sel, a, 1'b0, 4'h0, 32'h0);
        e.name = name; e.sel = sel; e.rdata = exp_rd; e.irq = exp_irq;
        q.push_back(e);
        chk_req = 1'b1;
        tick();
    endtask

    initial begin
        drive(1'b0, A_IN, 1'b0, 4'h0, 32'h0);
        drive(1'b1, A_IN, 1'b0, 4'h0, 32'h0);
        tick();
        // Reset held for two edges with pins high on u0
        chk(0, A_IN,   32'h0, 1'b0, "rst_in");
        chk(0, A_STAT, 32'h0, 1'b0, "rst_status");
        rst0 = 1'b0;
        rst4 = 1'b0;
        chk(0, A_RISE, 32'h0, 1'b0, "rst_rise_en");
        chk(0, A_IN,   32'h0, 1'b0, "post_rst_e1");
        chk(0, A_IN,   32'h0, 1'b0, "post_rst_e2");
        chk(0, A_IN,   32'hFF, 1'b0, "post_rst_e3");
        chk(0, A_STAT, 32'h0, 1'b0, "post_rst_status");

        // Rising edge on bit 0, DEBOUNCE=0
        g0 = 8'h00;
        repeat (4) tick();
        wr(0, A_IN, 4'hF, 32'hAA);
        chk(0, A_IN, 32'h0, 1'b0, "in_write_ignored");
        wr(0, A_RISE, 4'b0001, 32'h01);
        wr(0, A_RISE, 4'b1110, 32'hFFFF_FFFF);
        chk(0, A_RISE, 32'h01, 1'b0, "rise_en_lane_mask");
        g0 = 8'h01;
        chk(0, A_STAT, 32'h0,  1'b0, "rise_e0");
        chk(0, A_STAT, 32'h0,  1'b0, "rise_e1");
        chk(0, A_STAT, 32'h0,  1'b0, "rise_e2");
        chk(0, A_STAT, 32'h01, 1'b1, "rise_e3");
        wr(0, A_STAT, 4'hF, 32'h01);
        chk(0, A_STAT, 32'h0, 1'b0, "rise_w1c");

        // Falling edge on bit 7 only; rise on bit 6 not enabled
        g0 = 8'h81;
        repeat (4) tick();
        wr(0, A_RISE, 4'hF, 32'h0);
        wr(0, A_FALL, 4'hF, 32'h80);
        chk(0, A_FALL, 32'h80, 1'b0, "fall_en_rb");
        g0 = 8'h41;
        repeat (3) tick();
        chk(0, A_STAT, 32'h80, 1'b1, "fall_status");
        chk(0, A_IN,   32'h41, 1'b1, "fall_in");
        wr(0, A_STAT, 4'h0, 32'h80);
        chk(0, A_STAT, 32'h80, 1'b1, "w1c_mask0");
        wr(0, A_STAT, 4'hF, 32'hFF);
        chk(0, A_STAT, 32'h0, 1'b0, "w1c_all");

        // Set/clear collision on bit 3 while bit 6 clears normally
        wr(0, A_FALL, 4'hF, 32'hC0);
        wr(0, A_RISE, 4'hF, 32'h08);
        g0 = 8'h01;
        repeat (3) tick();
        chk(0, A_STAT, 32'h40, 1'b1, "coll_pre");
        g0 = 8'h09;
        tick();
        tick();
        wr(0, A_STAT, 4'hF, 32'h48);
        chk(0, A_STAT, 32'h08, 1'b1, "coll_set_wins");
        chk(0, A_IN,   32'h09, 1'b1, "coll_in");

        // Debounce: 4-cycle pulse rejected, longer pulse accepted at n+6
        wr(1, A_RISE, 4'hF, 32'h04);
        g4 = 8'h04;
        repeat (4) chk(1, A_IN, 32'h0, 1'b0, "deb_short_hi");
        g4 = 8'h00;
        repeat (4) chk(1, A_IN, 32'h0, 1'b0, "deb_short_lo");
        chk(1, A_STAT, 32'h0, 1'b0, "deb_short_status");
        g4 = 8'h04;
        repeat (7) chk(1, A_IN, 32'h0, 1'b0, "deb_long_wait");
        chk(1, A_IN,   32'h04, 1'b1, "deb_long_in");
        chk(1, A_STAT, 32'h04, 1'b1, "deb_long_status");

        // Reset in the middle of a debounce count
        wr(1, A_STAT, 4'hF, 32'hFF);
        wr(1, A_RISE, 4'hF, 32'h06);
        g4 = 8'h06;
        repeat (3) chk(1, A_IN, 32'h04, 1'b0, "mid_pre");
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        repeat (7) chk(1, A_IN, 32'h0, 1'b0, "mid_restart");
        chk(1, A_IN,   32'h06, 1'b0, "mid_in_after");
        chk(1, A_STAT, 32'h0,  1'b0, "mid_status");
        chk(1, A_RISE, 32'h0,  1'b0, "mid_rise_en");
        chk(1, A_FALL, 32'h0,  1'b0, "mid_fall_en");

        tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
        end
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog: bench did not complete, expected completion within 100000 time units");
            $fatal(1, "watchdog expired");
        end
    end
endmodule

// File: doc/gpio_in.md
# gpio_in

Memory-mapped general-purpose input peripheral on the CPU's single-cycle IO bus; the input-side counterpart of the GPIO output block. It synchronizes asynchronous input pins into `clk`, optionally debounces them, and detects per-pin rising and falling edges. Edges latch into a sticky status register with write-1-to-clear semantics, and the OR of the status bits drives an interrupt line to the core.

## Interface
- `WIDTH`, 8: number of input pins, from 1 to 32.
- `DEBOUNCE`, 0: number of stable cycles required before the filtered value follows the pin. 0 disables filtering. Counter width is `$clog2(DEBOUNCE+1)`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `io_addr`  in  32  byte address. Only `[3:2]` is decoded; the upstream decoder handles block select.
- `io_op`  in  1  1 = write this cycle, 0 = idle or read.
- `io_mask`  in  4  byte-lane write enables for `io_wdata`.
- `io_wdata`  in  32  write data.
- `io_rdata`  out  32  read data, combinational from `io_addr`.
- `io_gpio`  in  WIDTH  asynchronous input pins.
- `io_irq`  out  1  level interrupt, equal to `|status`.

## Operation
Register map by `io_addr[3:2]`. Unused upper bits read as 0.
- 0x0 `IN`: read-only, returns `filt`. Writes are ignored.
- 0x4 `RISE_EN`: read/write. Bit i enables latching of 0→1 transitions of `filt[i]`.
- 0x8 `FALL_EN`: read/write. Bit i enables latching of 1→0 transitions of `filt[i]`.
- 0xC `STATUS`: read; write-1-to-clear. Writing 0 to a bit leaves it unchanged. Reading has no side effect.

Writes:
- Honored only when `io_op`=1.
- Byte lane k of `io_wdata` applies only if `io_mask[k]`=1. For STATUS, a masked-off lane clears nothing.

Input path, per bit:
- Two-flop synchronizer: `s1 <= io_gpio`, `s2 <= s1`.
- Debounce counter `cnt`:
  - If `s2 == filt`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE`: `filt <= s2`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
- A change in `s2` lasting fewer than `DEBOUNCE+1` cycles never reaches `filt`.

Edge detection, per bit:
- `rise = (s2 & ~filt)` at the cycle `filt` updates; `fall` likewise.
- Set `status[i]` when the enabled edge occurs in the same cycle that `filt[i]` updates.

Priority for STATUS:
- If set and a W1C clear of the same bit coincide, set wins and the bit stays 1.
- Clears on other bits proceed normally.

Reset (`rst`=1 at a clock edge):
- `s1`, `s2`, `filt`, `cnt`, `RISE_EN`, `FALL_EN`, `STATUS` all go to 0.
- Outputs: `io_irq`=0; `io_rdata` follows the reset register values.
- Reset mid-debounce discards any partial count.
- An input held high through reset updates `filt` after release but sets no status, because the enables are 0.

## Timing
- `io_rdata`: same-cycle combinational read of register contents. A write is visible on a read in the following cycle.
- Pin-to-IN latency:
  - Pin change settled before edge n. `s1` captures at edge n, `s2` at n+1.
  - `filt` updates at edge `n+2+DEBOUNCE` if the pin is held stable.
  - With `DEBOUNCE`=0: 3 edges.
- Pin-to-IRQ latency:
  - `status` sets at the same edge `filt` updates.
  - `io_irq` rises combinationally after that edge.
- W1C: the status bit clears at the write edge, and `io_irq` drops in the next cycle if no other bits are set.
- The bus has no wait states; every access completes in one cycle.

## Test plan
- **Reset values.** Assert `rst` 2 cycles with `io_gpio`=0xFF. Expect all registers 0 and `io_irq`=0 during reset. After release, IN reads 0xFF by the 3rd edge and STATUS stays 0.
- **Rising-edge interrupt.** `DEBOUNCE`=0; write `RISE_EN`=0x01 with mask 4'b0001; drive `io_gpio[0]` 0→1. Expect STATUS=0x01 and `io_irq`=1 exactly 3 edges after the pin change. Write 0x01 to 0xC: STATUS=0 and `io_irq`=0.
- **Falling edge and masking.** Enable `FALL_EN`=0x80 and `RISE_EN`=0. Toggle bit 7 1→0 and bit 6 0→1. Expect STATUS=0x80 only. A W1C write of 0x80 with `io_mask`=0 leaves STATUS=0x80.
- **Debounce.** `DEBOUNCE`=4. A 4-cycle high pulse on bit 2 leaves IN[2]=0 and STATUS=0. A 5-cycle-or-longer stable high updates IN[2]=1 at edge n+6 and sets STATUS[2] if rise is enabled.
- **Set/clear collision.** Arrange the `filt[3]` rising update on the same edge as a W1C write of 0x08. Expect STATUS[3]=1 afterwards and `io_irq` held high.
- **Mid-operation reset.** `DEBOUNCE`=4; assert `rst` for 1 cycle in the middle of a debounce count. Expect `cnt` restarted, all enables 0, and no status set by the pending edge.
